// File: rtl/leaf_rule_matcher_pkg.sv
// FSM state encoding for the leaf rule matcher.
package leaf_rule_matcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lrm_state_e;

endpackage

// File: rtl/network_pkg.sv
// Shared packet, rule and leaf-node types used by the classifier pipeline.
package network_pkg;

    localparam int MAX_RULES_PER_NODE = 8;

    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] port;
    } endpoint_s;

    // 109-bit header; flags ride along but take no part in rule matching.
    typedef struct packed {
        endpoint_s   src;
        endpoint_s   dst;
        logic [7:0]  protocol;
        logic [4:0]  flags;
    } packet_s;

    typedef struct packed {
        logic [31:0] start;
        logic [31:0] last;
    } range32_s;

    typedef struct packed {
        logic [15:0] start;
        logic [15:0] last;
    } range16_s;

    typedef struct packed {
        logic [7:0] start;
        logic [7:0] last;
    } range8_s;

    typedef struct packed {
        range32_s    src_ip;
        range16_s    src_port;
        range32_s    dst_ip;
        range16_s    dst_port;
        range8_s     protocol;
        logic [31:0] weight;
    } rule_s;

    typedef struct packed {
        logic [31:0]                       rule_count;
        rule_s [MAX_RULES_PER_NODE-1:0]    rules;
    } node_s;

endpackage

// File: rtl/rule_match.sv
// Combinational inclusive range check of one packet header against one rule.
module rule_match
    import network_pkg::*;
(
    input  packet_s pkt_i,
    input  rule_s   rule_i,
    output logic    hit_o
);

    logic unused_bits;

    assign hit_o = (pkt_i.src.ip    >= rule_i.src_ip.start)   && (pkt_i.src.ip    <= rule_i.src_ip.last)
                && (pkt_i.src.port  >= rule_i.src_port.start) && (pkt_i.src.port  <= rule_i.src_port.last)
                && (pkt_i.dst.ip    >= rule_i.dst_ip.start)   && (pkt_i.dst.ip    <= rule_i.dst_ip.last)
                && (pkt_i.dst.port  >= rule_i.dst_port.start) && (pkt_i.dst.port  <= rule_i.dst_port.last)
                && (pkt_i.protocol  >= rule_i.protocol.start) && (pkt_i.protocol  <= rule_i.protocol.last);

    assign unused_bits = ^{pkt_i.flags, rule_i.weight};

endmodule

// File: rtl/leaf_rule_matcher.sv
// Scans a latched leaf one rule per cycle and reports the lowest-weight match.
//   state | meaning
//   IDLE  | ready for a packet + leaf
//   SCAN  | evaluating slot idx_q, one per cycle
//   DONE  | result presented until result_ready_in
module leaf_rule_matcher
    import network_pkg::*;
    import leaf_rule_matcher_pkg::*;
#(
    parameter int MAX_RULES_PER_NODE = network_pkg::MAX_RULES_PER_NODE,
    localparam int IDX_W = $clog2(MAX_RULES_PER_NODE)
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   pkt_valid_in,
    output logic                                   pkt_ready_out,
    input  packet_s                                pkt_in,
    input  logic [31:0]                            rule_count_in,
    input  rule_s [MAX_RULES_PER_NODE-1:0]         rules_in,
    output logic                                   result_valid_out,
    input  logic                                   result_ready_in,
    output logic                                   match_found_out,
    output logic [IDX_W-1:0]                       match_index_out,
    output logic [31:0]                            match_weight_out
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] N_MAX = CNT_W'(MAX_RULES_PER_NODE);

    lrm_state_e                      state_q, state_d;
    packet_s                         pkt_q, pkt_d;
    rule_s [MAX_RULES_PER_NODE-1:0]  rules_q, rules_d;
    logic [CNT_W-1:0]                n_q, n_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            best_found_q, best_found_d;
    logic [IDX_W-1:0]                best_idx_q, best_idx_d;
    logic [31:0]                     best_weight_q, best_weight_d;

    logic             accept;
    logic             hit;
    logic             better;
    logic             last_slot;
    logic [CNT_W-1:0] n_clamped;

    // Ready is masked during reset so nothing looks acceptable while rst_in is high.
    assign pkt_ready_out = (state_q == IDLE) && !rst_in;
    assign accept        = pkt_valid_in && pkt_ready_out;
    assign n_clamped     = (rule_count_in >= 32'(MAX_RULES_PER_NODE)) ? N_MAX
                                                                     : rule_count_in[CNT_W-1:0];
    assign last_slot     = ({1'b0, idx_q} == (n_q - CNT_W'(1)));

    rule_match u_rule_match (
        .pkt_i  (pkt_q),
        .rule_i (rules_q[idx_q]),
        .hit_o  (hit)
    );

    // Strict less-than keeps the earlier slot on a weight tie.
    assign better = hit && (!best_found_q || (rules_q[idx_q].weight < best_weight_q));

    always_comb begin
        state_d       = state_q;
        pkt_d         = pkt_q;
        rules_d       = rules_q;
        n_d           = n_q;
        idx_d         = idx_q;
        best_found_d  = best_found_q;
        best_idx_d    = best_idx_q;
        best_weight_d = best_weight_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pkt_d         = pkt_in;
                    rules_d       = rules_in;
                    n_d           = n_clamped;
                    idx_d         = '0;
                    best_found_d  = 1'b0;
                    best_idx_d    = '0;
                    best_weight_d = '0;
                    state_d       = (n_clamped == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (better) begin
                    best_found_d  = 1'b1;
                    best_idx_d    = idx_q;
                    best_weight_d = rules_q[idx_q].weight;
                end
                idx_d = idx_q + IDX_W'(1);
                if (last_slot) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            pkt_q         <= '0;
            rules_q       <= '0;
            n_q           <= '0;
            idx_q         <= '0;
            best_found_q  <= 1'b0;
            best_idx_q    <= '0;
            best_weight_q <= '0;
        end else begin
            state_q       <= state_d;
            pkt_q         <= pkt_d;
            rules_q       <= rules_d;
            n_q           <= n_d;
            idx_q         <= idx_d;
            best_found_q  <= best_found_d;
            best_idx_q    <= best_idx_d;
            best_weight_q <= best_weight_d;
        end
    end

    assign result_valid_out = (state_q == DONE);
    assign match_found_out  = result_valid_out && best_found_q;
    assign match_index_out  = match_found_out ? best_idx_q : '0;
    assign match_weight_out = match_found_out ? best_weight_q : '0;

endmodule

// File: doc/leaf_rule_matcher.md
LEAF_RULE_MATCHER -- requirements
Module: leaf_rule_matcher

Interface
REQ-001 SHALL have parameter MAX_RULES_PER_NODE, default 8, meaning the rule slots per leaf (power of two, at least 2).
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all state is on the rising edge.
REQ-003 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port pkt_valid_in, input, 1 bit: a packet and its leaf are offered.
REQ-005 SHALL have port pkt_ready_out, output, 1 bit: the block accepts the offer.
REQ-006 SHALL have port pkt_in, input, packet_s (109 bits): the header to classify.
REQ-007 SHALL have port rule_count_in, input, 32 bits: the leaf's rule_count.
REQ-008 SHALL have port rules_in, input, rule_s[MAX_RULES_PER_NODE-1:0]: the leaf's rule array.
REQ-009 SHALL have port result_valid_out, output, 1 bit: a classification result is presented.
REQ-010 SHALL have port result_ready_in, input, 1 bit: the downstream stage takes the result.
REQ-011 SHALL have port match_found_out, output, 1 bit: at least one rule matched.
REQ-012 SHALL have port match_index_out, output, $clog2(MAX_RULES_PER_NODE) bits: the slot of the winning rule.
REQ-013 SHALL have port match_weight_out, output, 32 bits: the weight of the winning rule.

Function
REQ-014 An offer SHALL be accepted on a clock edge where pkt_valid_in and pkt_ready_out are both 1.
- On acceptance, pkt_in, rules_in and the count SHALL be latched.
- The count SHALL be clamped: N = min(rule_count_in, MAX_RULES_PER_NODE).
REQ-015 The FSM SHALL have three states: IDLE, SCAN and DONE.
- pkt_ready_out SHALL be 1 only in IDLE.
- result_valid_out SHALL be 1 only in DONE.
REQ-016 State transitions SHALL be:
- IDLE to SCAN on acceptance when N>0, with idx=0.
- IDLE to DONE on acceptance when N=0, with no match.
- SCAN to DONE after evaluating idx=N-1.
- DONE to IDLE on an edge where result_ready_in=1.
REQ-017 SCAN SHALL evaluate exactly one rule per cycle, at slot idx, then increment idx.
REQ-018 A rule SHALL match when every field satisfies start<=field<=last, unsigned and inclusive on both ends.
- The fields are src.ip, src.port, dst.ip, dst.port and protocol.
REQ-019 Selection SHALL pick the matching rule with the smallest weight.
- On equal weights, the lower index SHALL win.
- The best candidate SHALL be held in registers.
REQ-020 Latency SHALL be max(N,1) cycles: result_valid_out rises max(N,1) edges after the acceptance edge.
REQ-021 match_index_out and match_weight_out SHALL be 0 when match_found_out=0.
REQ-022 Result outputs SHALL hold stable while result_valid_out=1 and result_ready_in=0.
REQ-023 A new packet SHALL NOT be accepted in the same edge that a result is taken, because DONE goes to IDLE first.
REQ-024 Input changes outside IDLE SHALL NOT affect the result in progress.
REQ-025 Slots at or above N SHALL never be evaluated.

Reset
REQ-026 While rst_in=1, the outputs SHALL be:
- state IDLE;
- pkt_ready_out 0;
- result_valid_out 0;
- match_found_out 0, match_index_out 0, match_weight_out 0.
REQ-027 Reset asserted mid-SCAN or mid-DONE SHALL discard the in-flight packet and produce no result.
REQ-028 pkt_ready_out SHALL be 1 from the first cycle after rst_in deasserts.

Structure
REQ-029 MAX_RULES_PER_NODE SHALL be defined in network_pkg so node_s and this block share it.
- packet_s, rule_s and the state enum SHALL come from shared packages.
REQ-030 The per-rule range comparison SHALL be one combinational sub-module, rule_match, which takes a packet_s and a rule_s and outputs a 1-bit hit.

Verification
REQ-031 Scenario: one rule equal to the packet on all fields (start=last=pkt), N=1. Required: match_found=1, index=0, one-cycle latency.
REQ-032 Scenario: N=4, rules 1 and 3 match with weights 7 and 3. Required: index=3, weight=3, latency 4.
REQ-033 Scenario: N=4, rules 0 and 2 match, both with weight 5. Required: index=0.
REQ-034 Scenario: src.port one above last on rule 0, N=1. Required: match_found=0, index=0, weight=0.
REQ-035 Scenario: rule_count_in=100 with MAX=8. Required: 8 cycles of scan. Separately, rule_count_in=0. Required: a no-match result after 1 cycle.
REQ-036 Scenario: result_ready_in held at 0 for 5 cycles, then rst_in pulsed in the middle of a new SCAN. Required: outputs stable through the stall; no result after the reset; pkt_ready_out returns to 1.
